// File: rtl/shift_rotate_unit_pkg.sv
// Shared definitions for the shift/rotate engine: op codes, FSM state
// encoding and a constant-evaluable ceil(log2) helper for sizing.
package shift_rotate_unit_pkg;

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHRA = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_rotate_unit_shift_step.sv
// Combinational single-step mover. Each level moves the word by a fixed
// power of two when the matching step bit is set, so any step in
// 0..MAX_STEP is composed from log2(MAX_STEP)+1 constant-distance levels.
module shift_step
  import shift_rotate_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 8,
  parameter int STEP_W   = clog2(MAX_STEP) + 1
) (
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  work,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  next_work
);

  // Move x by a constant distance s according to op. Reserved ops pass
  // through unchanged. A rotate by WIDTH degenerates to identity because
  // x << WIDTH is zero and x >> 0 is x.
  function automatic logic [WIDTH-1:0] move(input logic [2:0]       o,
                                            input logic [WIDTH-1:0] x,
                                            input int               s);
    case (o)
      OP_SHL:  move = x << s;
      OP_SHR:  move = x >> s;
      OP_SHRA: move = $signed(x) >>> s;
      OP_ROL:  move = (x << s) | (x >> (WIDTH - s));
      OP_ROR:  move = (x >> s) | (x << (WIDTH - s));
      default: move = x;
    endcase
  endfunction

  logic [STEP_W:0][WIDTH-1:0] stage;

  assign stage[0] = work;

  for (genvar k = 0; k < STEP_W; k++) begin : g_level
    assign stage[k+1] = step[k] ? move(op, stage[k], 1 << k) : stage[k];
  end

  assign next_work = stage[STEP_W];

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate engine with a start/busy/done handshake.
// Moves at most MAX_STEP positions per clock; result is registered and
// held until the next operation completes or clear is asserted.
module shift_rotate_unit
  import shift_rotate_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_STEP  = 8,
  parameter int AMT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [AMT_WIDTH-1:0] amount,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result
);

  localparam int LOG_W  = clog2(WIDTH);
  localparam int REM_W  = LOG_W + 1;          // holds 0..WIDTH
  localparam int STEP_W = clog2(MAX_STEP) + 1; // holds 0..MAX_STEP

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [REM_W-1:0]   eff;
  logic [STEP_W-1:0]  step;
  logic [REM_W-1:0]   rem_after;
  logic [WIDTH-1:0]   next_work;

  // Effective count for the incoming request: rotates wrap modulo WIDTH,
  // shifts saturate at WIDTH using the full amount, reserved ops do nothing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    eff = '0;
    case (op)
      OP_SHL, OP_SHR, OP_SHRA: begin
        if (amount >= AMT_WIDTH'(WIDTH)) eff = REM_W'(WIDTH);
        else                             eff = amount[REM_W-1:0];
      end
      OP_ROL, OP_ROR: eff = REM_W'(amount[LOG_W-1:0]);
      default:        eff = '0;
    endcase
  end

  // Per-cycle step is the remaining count capped at MAX_STEP.
  always_comb begin
    step = '0;
    if (rem_q > REM_W'(MAX_STEP)) step = STEP_W'(MAX_STEP);
    else                          step = STEP_W'(rem_q);
    rem_after = rem_q - REM_W'(step);
  end

  shift_step #(
    .WIDTH    (WIDTH),
    .MAX_STEP (MAX_STEP),
    .STEP_W   (STEP_W)
  ) u_shift_step (
    .op        (op_q),
    .work      (work_q),
    .step      (step),
    .next_work (next_work)
  );

  // Next-state logic: accept in IDLE or DONE, step in SHIFT, and load the
  // result register only on the transition into DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d   = op;
          work_d = data_in;
          rem_d  = eff;
          if (eff != '0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d  = ST_DONE;
            result_d = data_in;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = next_work;
        rem_d  = rem_after;
        if (rem_after == '0) begin
          state_d  = ST_DONE;
          result_d = next_work;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous clear that also discards any
  // in-flight operation.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (clear) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule
